// File: rtl/tls_pkg.sv
// Shared constants and the per-flow table entry layout for the TLS flow classifier.
package tls_pkg;

    // Flow class codes reported on o_res_type
    localparam logic [2:0] TYPE_UNKNOWN   = 3'b000;
    localparam logic [2:0] TYPE_TCP_HELLO = 3'b001;
    localparam logic [2:0] TYPE_UDP_HELLO = 3'b010;
    localparam logic [2:0] TYPE_TCP_CONF  = 3'b101;
    localparam logic [2:0] TYPE_UDP_CONF  = 3'b110;

    // IP protocol numbers
    localparam logic [7:0] PROTO_TCP = 8'h06;
    localparam logic [7:0] PROTO_UDP = 8'h11;

    // TLS record header bytes
    localparam logic [7:0] REC_HANDSHAKE    = 8'h16;
    localparam logic [7:0] REC_APP_DATA     = 8'h17;
    localparam logic [7:0] REC_VER_MAJOR    = 8'h03;
    localparam logic [7:0] REC_CLIENT_HELLO = 8'h01;
    localparam logic [7:0] REC_MINOR_MIN    = 8'h01;
    localparam logic [7:0] REC_MINOR_MAX    = 8'h03;
    localparam logic [7:0] REC_APP_MINOR    = 8'h03;

    // One flow-table entry; all-zero is the idle/cleared state
    typedef struct packed {
        logic       hello;
        logic       app_flag;
        logic [2:0] pass_cnt;
        logic       proto;      // 0 TCP, 1 UDP
        logic [2:0] etype;
    } entry_t;

endpackage

// File: rtl/tls_entry_update.sv
// Next-state function of one flow-table entry given the decoded header flags.
module tls_entry_update
    import tls_pkg::*;
#(
    parameter int unsigned PASS_THR = 4
) (
    input  entry_t cur,
    input  logic   hello,
    input  logic   app,
    input  logic   udp,
    output entry_t next_entry_c
);

    // Hello latches protocol and class; app records arm then count toward confirmation
    always_comb begin
        next_entry_c = cur;
        if (hello) begin
            next_entry_c.hello = 1'b1;
            next_entry_c.proto = udp;
            next_entry_c.etype = udp ? TYPE_UDP_HELLO : TYPE_TCP_HELLO;
        end
        if (app) begin
            if (!cur.app_flag) begin
                next_entry_c.app_flag = 1'b1;
            end else if (cur.pass_cnt < 3'(PASS_THR)) begin
                next_entry_c.pass_cnt = cur.pass_cnt + 3'd1;
            end
        end
        // A confirmed flow stays confirmed; class follows the current beat's protocol
        if ((hello || app) && (next_entry_c.pass_cnt == 3'(PASS_THR))) begin
            next_entry_c.etype = udp ? TYPE_UDP_CONF : TYPE_TCP_CONF;
        end
    end

endmodule

// File: rtl/tls_flow_classifier.sv
// Per-flow TLS classifier: S1 registers inputs and reads the flow table,
// S2 writes the updated entry back and reports window-close results.
module tls_flow_classifier
    import tls_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned FLOW_ID_W = 8,
    parameter int unsigned PASS_THR  = 4,
    parameter int unsigned WIN_PKTS  = 4,
    parameter int unsigned END_CYCLE = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pkt_data_valid,
    input  logic [DATA_W-1:0]    i_pkt_data,
    input  logic [7:0]           i_pkt_len,
    input  logic [2:0]           i_pkt_num,
    input  logic [7:0]           i_pkt_protocol,
    input  logic [5:0]           i_pkt_cycle_cnt,
    input  logic [FLOW_ID_W-1:0] i_flow_id,
    output logic                 o_res_valid,
    output logic [FLOW_ID_W-1:0] o_res_flow_id,
    output logic [2:0]           o_res_type,
    output logic                 o_busy_err
);

    localparam int unsigned DEPTH = 2 ** FLOW_ID_W;

    // S1 input registers
    logic                 s1_valid;
    logic [DATA_W-1:0]    s1_data;
    logic [7:0]           s1_len;
    logic [2:0]           s1_num;
    logic [7:0]           s1_proto;
    logic [5:0]           s1_cyc;
    logic [FLOW_ID_W-1:0] s1_flow;

    // S2 write-back registers
    logic                 s2_valid;
    logic [FLOW_ID_W-1:0] s2_flow;
    entry_t               s2_entry;
    logic                 s2_close;

    entry_t flow_table [DEPTH];

    logic   hdr_c, hello_c, app_c, proto_ok_c, udp_c, close_c, fwd_c;
    entry_t rd_entry_c, upd_entry_c;
    logic   unused_bits;

    // Capture every input once; valid is dropped while in reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_len   <= '0;
            s1_num   <= '0;
            s1_proto <= '0;
            s1_cyc   <= '0;
            s1_flow  <= '0;
        end else begin
            s1_valid <= i_pkt_data_valid;
            s1_data  <= i_pkt_data;
            s1_len   <= i_pkt_len;
            s1_num   <= i_pkt_num;
            s1_proto <= i_pkt_protocol;
            s1_cyc   <= i_pkt_cycle_cnt;
            s1_flow  <= i_flow_id;
        end
    end

    // Header decode and entry read with S2 forwarding for back-to-back same-flow beats
    always_comb begin
        hdr_c      = s1_valid && (s1_cyc == 6'd1);
        proto_ok_c = (s1_proto == PROTO_TCP) || (s1_proto == PROTO_UDP);
        udp_c      = (s1_proto == PROTO_UDP);
        hello_c    = hdr_c && proto_ok_c
                     && (s1_data[7:0]   == REC_HANDSHAKE)
                     && (s1_data[15:8]  == REC_VER_MAJOR)
                     && (s1_data[23:16] >= REC_MINOR_MIN)
                     && (s1_data[23:16] <= REC_MINOR_MAX)
                     && (s1_data[47:40] == REC_CLIENT_HELLO);
        app_c      = hdr_c && proto_ok_c
                     && (s1_data[7:0]   == REC_APP_DATA)
                     && (s1_data[15:8]  == REC_VER_MAJOR)
                     && (s1_data[23:16] == REC_APP_MINOR);
        close_c    = s1_valid && (s1_num == 3'(WIN_PKTS)) && (s1_cyc == 6'(END_CYCLE));
        fwd_c      = s2_valid && (s2_flow == s1_flow);
        if (fwd_c) begin
            rd_entry_c = s2_close ? entry_t'('0) : s2_entry;
        end else begin
            rd_entry_c = flow_table[s1_flow];
        end
    end

    // Bytes 3..4, upper beat lanes and the length are not needed for classification
    assign unused_bits = ^{s1_data[DATA_W-1:48], s1_data[39:24], s1_len};

    tls_entry_update #(
        .PASS_THR (PASS_THR)
    ) u_entry_update (
        .cur          (rd_entry_c),
        .hello        (hello_c),
        .app          (app_c),
        .udp          (udp_c),
        .next_entry_c (upd_entry_c)
    );

    // S2 pipeline registers carrying the updated entry to the table write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_flow  <= '0;
            s2_entry <= '0;
            s2_close <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_flow  <= s1_flow;
            s2_entry <= upd_entry_c;
            s2_close <= close_c;
        end
    end

    // Flow table write-back; a closed window leaves the entry cleared
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                flow_table[i] <= '0;
            end
        end else if (s2_valid) begin
            flow_table[s2_flow] <= s2_close ? entry_t'('0) : s2_entry;
        end
    end

    // Result strobe alongside S2; id/type hold between results, error is sticky
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_valid   <= 1'b0;
            o_res_flow_id <= '0;
            o_res_type    <= '0;
            o_busy_err    <= 1'b0;
        end else begin
            o_res_valid <= close_c;
            if (close_c) begin
                o_res_flow_id <= s1_flow;
                o_res_type    <= upd_entry_c.etype;
            end
            if (s1_valid && !proto_ok_c) begin
                o_busy_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tls_flow_classifier.sv
// Directed bench for tls_flow_classifier: table of per-flow scenarios plus hand sequences.
module tb_tls_flow_classifier;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_pkt_data_valid;
    logic [63:0] i_pkt_data;
    logic [7:0]  i_pkt_len;
    logic [2:0]  i_pkt_num;
    logic [7:0]  i_pkt_protocol;
    logic [5:0]  i_pkt_cycle_cnt;
    logic [7:0]  i_flow_id;
    logic        o_res_valid;
    logic [7:0]  o_res_flow_id;
    logic [2:0]  o_res_type;
    logic        o_busy_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] flow;
        logic [7:0] proto;
        logic [7:0] b2;
        int         n_hello;
        int         n_app;
        logic [2:0] exp_type;
    } vec_t;

    localparam int NV = 11;
    vec_t vec [NV];

    tls_flow_classifier dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_pkt_data_valid (i_pkt_data_valid),
        .i_pkt_data       (i_pkt_data),
        .i_pkt_len        (i_pkt_len),
        .i_pkt_num        (i_pkt_num),
        .i_pkt_protocol   (i_pkt_protocol),
        .i_pkt_cycle_cnt  (i_pkt_cycle_cnt),
        .i_flow_id        (i_flow_id),
        .o_res_valid      (o_res_valid),
        .o_res_flow_id    (o_res_flow_id),
        .o_res_type       (o_res_type),
        .o_busy_err       (o_busy_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b5);
        logic [63:0] d;
        d        = 64'h0;
        d[7:0]   = b0;
        d[15:8]  = b1;
        d[23:16] = b2;
        d[47:40] = b5;
        return d;
    endfunction

    task automatic beat(input logic [7:0] flow, input logic [7:0] proto, input logic [63:0] data,
                        input logic [2:0] num, input logic [5:0] cyc);
        i_pkt_data_valid = 1'b1;
        i_flow_id        = flow;
        i_pkt_protocol   = proto;
        i_pkt_data       = data;
        i_pkt_num        = num;
        i_pkt_cycle_cnt  = cyc;
        i_pkt_len        = 8'd64;
        @(posedge i_clk);
        #1;
        i_pkt_data_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic close_beat(input logic [7:0] flow, input logic [7:0] proto);
        beat(flow, proto, 64'h0, 3'd4, 6'd32);
    endtask

    task automatic hello(input logic [7:0] flow, input logic [7:0] proto, input logic [7:0] b2);
        beat(flow, proto, hdr(8'h16, 8'h03, b2, 8'h01), 3'd1, 6'd1);
    endtask

    task automatic app(input logic [7:0] flow, input logic [7:0] proto);
        beat(flow, proto, hdr(8'h17, 8'h03, 8'h03, 8'h00), 3'd1, 6'd1);
    endtask

    initial begin
        vec[0]  = '{8'd5,   8'h06, 8'h01, 1, 0, 3'b001};
        vec[1]  = '{8'd9,   8'h11, 8'h01, 1, 5, 3'b110};
        vec[2]  = '{8'd7,   8'h06, 8'h01, 0, 5, 3'b101};
        vec[3]  = '{8'd8,   8'h06, 8'h01, 0, 4, 3'b000};
        vec[4]  = '{8'd10,  8'h11, 8'h01, 0, 7, 3'b110};
        vec[5]  = '{8'd11,  8'h11, 8'h03, 1, 0, 3'b010};
        vec[6]  = '{8'd12,  8'h06, 8'h04, 1, 0, 3'b000};
        vec[7]  = '{8'd13,  8'h06, 8'h00, 1, 0, 3'b000};
        vec[8]  = '{8'd5,   8'h06, 8'h01, 0, 0, 3'b000};
        vec[9]  = '{8'd14,  8'h06, 8'h02, 1, 4, 3'b001};
        vec[10] = '{8'd255, 8'h11, 8'h01, 1, 5, 3'b110};

        i_rst_n          = 1'b0;
        i_pkt_data_valid = 1'b0;
        i_pkt_data       = '0;
        i_pkt_len        = '0;
        i_pkt_num        = '0;
        i_pkt_protocol   = '0;
        i_pkt_cycle_cnt  = '0;
        i_flow_id        = '0;
        idle();
        idle();
        chk("rst_valid", 32'(o_res_valid), 32'd0);
        chk("rst_id",    32'(o_res_flow_id), 32'd0);
        chk("rst_type",  32'(o_res_type), 32'd0);
        chk("rst_err",   32'(o_busy_err), 32'd0);
        i_rst_n = 1'b1;
        idle();

        // Table-driven per-flow scenarios; app beats are back to back with the close
        for (int v = 0; v < NV; v++) begin
            if (vec[v].n_hello != 0) hello(vec[v].flow, vec[v].proto, vec[v].b2);
            for (int a = 0; a < vec[v].n_app; a++) app(vec[v].flow, vec[v].proto);
            close_beat(vec[v].flow, vec[v].proto);
            idle();
            chk($sformatf("vec%0d_valid", v), 32'(o_res_valid), 32'd1);
            chk($sformatf("vec%0d_id", v),    32'(o_res_flow_id), 32'(vec[v].flow));
            chk($sformatf("vec%0d_type", v),  32'(o_res_type), 32'(vec[v].exp_type));
            idle();
            chk($sformatf("vec%0d_pulse", v), 32'(o_res_valid), 32'd0);
            chk($sformatf("vec%0d_hold", v),  32'(o_res_type), 32'(vec[v].exp_type));
        end
        chk("no_err", 32'(o_busy_err), 32'd0);

        // Flows 3 and 4 interleaved beat by beat
        for (int i = 0; i < 5; i++) begin
            if (i == 0) hello(8'd3, 8'h06, 8'h01);
            else beat(8'd3, 8'h06, 64'h0, 3'd1, 6'd2);
            app(8'd4, 8'h11);
        end
        close_beat(8'd3, 8'h06);
        close_beat(8'd4, 8'h11);
        chk("ilv3_valid", 32'(o_res_valid), 32'd1);
        chk("ilv3_id",    32'(o_res_flow_id), 32'd3);
        chk("ilv3_type",  32'(o_res_type), 32'(3'b001));
        idle();
        chk("ilv4_valid", 32'(o_res_valid), 32'd1);
        chk("ilv4_id",    32'(o_res_flow_id), 32'd4);
        chk("ilv4_type",  32'(o_res_type), 32'(3'b110));
        idle();

        // Bad protocol hello on flow 1: sticky error, no entry update
        hello(8'd1, 8'h01, 8'h01);
        idle();
        chk("bad_err", 32'(o_busy_err), 32'd1);
        close_beat(8'd1, 8'h06);
        idle();
        chk("bad_valid", 32'(o_res_valid), 32'd1);
        chk("bad_type",  32'(o_res_type), 32'(3'b000));
        chk("bad_sticky", 32'(o_busy_err), 32'd1);

        // Reset mid-flow after a hello on flow 2 clears the table
        hello(8'd2, 8'h06, 8'h01);
        idle();
        idle();
        i_rst_n = 1'b0;
        #2;
        chk("mid_rst_err",  32'(o_busy_err), 32'd0);
        chk("mid_rst_id",   32'(o_res_flow_id), 32'd0);
        chk("mid_rst_type", 32'(o_res_type), 32'd0);
        idle();
        i_rst_n = 1'b1;
        idle();
        close_beat(8'd2, 8'h06);
        idle();
        chk("rst2_valid", 32'(o_res_valid), 32'd1);
        chk("rst2_id",    32'(o_res_flow_id), 32'd2);
        chk("rst2_type",  32'(o_res_type), 32'(3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
